alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Execute-stage controller for the Nibbler 4-bit datapath, on the driving side of the ALU's A/B/S and Y/ZERO/C_out interface. Accepts one decoded instruction (opcode + 4-bit immediate) per valid/ready handshake. Sequences the ALU select and operands, then writes back the accumulator, C/Z flags and output port. Also evaluates conditional-branch predicates. The ALU is instantiated beside this block at the datapath top level.

Parameters:
WIDTH, 4, datapath width; fixed at 4 to match the ALU, no other value supported
OPW, 4, opcode width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
instr_valid  in  1  instruction present
instr_ready  out  1  block can accept; high only in IDLE
instr_op  in  OPW  opcode
instr_imm  in  WIDTH  immediate operand
in_port  in  WIDTH  external input nibble
alu_a  out  WIDTH  to ALU A
alu_b  out  WIDTH  to ALU B
alu_s  out  3  to ALU S
alu_y  in  WIDTH  from ALU Y
alu_zero  in  1  from ALU ZERO
alu_cout  in  1  from ALU C_out
acc  out  WIDTH  accumulator
flag_c  out  1  carry/borrow flag
flag_z  out  1  zero flag
out_port  out  WIDTH  output register
done  out  1  one-cycle retire pulse
branch_taken  out  1  one-cycle predicate pulse
illegal  out  1  one-cycle pulse for an undefined opcode

Behaviour:
- Reset (synchronous, high): state=IDLE; acc, flag_c, flag_z and out_port=0; done, branch_taken and illegal=0. Reset wins over every other event. Asserting reset in EXEC or EXEC2 aborts the instruction with no writeback and no done.
- ALU select codes: PASS_A=0, SUB=1, PASS_B=2, ADD=3, NAND=4.
- Idle ALU drive (IDLE): alu_a=acc, alu_b=0, alu_s=PASS_A.
- States: IDLE -> EXEC -> (EXEC2 for ADC only) -> IDLE.
  - IDLE: instr_ready=1. On instr_valid, latch op and imm, then go to EXEC.
  - In EXEC/EXEC2: instr_ready=0; instr_valid is ignored.
- Timing: handshake at edge k; EXEC is cycle k..k+1; writeback at edge k+1, or k+2 for ADC. done is high in the cycle after writeback, which is the IDLE cycle. Peak throughput is one instruction per 2 cycles, or 3 for ADC.
- In EXEC, alu_a=acc and alu_b=imm unless stated otherwise. Opcodes:
  - 0 NOP: no ALU use; done only.
  - 1 LIT: S=PASS_B; acc<=Y; Z<=ZERO.
  - 2 ADDI: S=ADD; acc<=Y; C<=C_out; Z<=ZERO. Sum is modulo 16.
  - 3 CMPI: S=SUB; acc unchanged; C<=C_out (acc<imm, unsigned); Z<=ZERO.
  - 4 NANDI: S=NAND; acc<=Y; Z<=ZERO; C unchanged.
  - 5 IN: S=PASS_B with alu_b=in_port, sampled in the EXEC cycle; acc<=Y; Z<=ZERO.
  - 6 OUT: S=PASS_A; out_port<=Y; flags unchanged.
  - 7 JC / 8 JZ / 9 JNC / 10 JNZ: no ALU use. branch_taken pulses with done and equals the predicate on the current flags.
  - 11 ADC:
    - EXEC: S=ADD, a=acc, b=imm; register t<=Y and c1<=C_out.
    - EXEC2: S=ADD, a=t, b={000,flag_c}, using the flag_c value from before the instruction.
    - Writeback: acc<=Y; C<=c1|C_out; Z<=ZERO.
  - 12-15: illegal pulses with done; acc, flags and out_port unchanged.
- Flags change only as listed above. done, branch_taken and illegal are registered, never combinational.

Decomposition:
- Package nibbler_pkg holds:
  - ALU select localparams (PASS_A, SUB, PASS_B, ADD, NAND);
  - opcode localparams (NOP..ADC);
  - state encoding (IDLE, EXEC, EXEC2).
- The ALU itself uses the same select constants.
- No sub-module; the flag/accumulator writeback stays inline.

Test Plan:
- Reset, then LIT 0x9 -> in EXEC alu_s=2 and alu_b=9. Next cycle acc=9, Z=0, C=0, done=1 for one cycle, instr_ready=1.
- LIT 0xF, then ADDI 0x3 -> acc=0x2, C=1, Z=0. Then NANDI 0xF -> acc=0xD, C still 1, Z=0.
- LIT 0x5, CMPI 0x5 -> acc=5, Z=1, C=0. Then CMPI 0x7 -> acc=5, C=1, Z=0.
- LIT 0xF, ADDI 0x1 gives acc=0, C=1, Z=1. Then ADC 0xF:
  - EXEC computes 0+F=F with c1=0;
  - EXEC2 computes F+1=0;
  - result acc=0, C=1, Z=1, done two cycles after EXEC entry.
- With Z=1: JZ -> branch_taken=1; JNZ -> branch_taken=0. Opcode 0xC -> illegal=1 with done, acc and flags unchanged. OUT with acc=0x0 -> out_port=0x0.
- Reset asserted during EXEC2 of ADC (acc=7 before) -> next cycle acc=0, flags=0, done=0, instr_ready=1. instr_valid held during EXEC is not accepted until IDLE.

Source files
------------

// File: rtl/nibbler_pkg.sv
// Shared constants for the Nibbler 4-bit datapath: ALU select codes,
// opcode map and execute-stage state encoding. The ALU uses the same
// select constants.
package nibbler_pkg;

  localparam int WIDTH = 4;
  localparam int OPW   = 4;

  localparam logic [2:0] ALU_PASS_A = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_PASS_B = 3'd2;
  localparam logic [2:0] ALU_ADD    = 3'd3;
  localparam logic [2:0] ALU_NAND   = 3'd4;

  localparam logic [OPW-1:0] OP_NOP   = 4'd0;
  localparam logic [OPW-1:0] OP_LIT   = 4'd1;
  localparam logic [OPW-1:0] OP_ADDI  = 4'd2;
  localparam logic [OPW-1:0] OP_CMPI  = 4'd3;
  localparam logic [OPW-1:0] OP_NANDI = 4'd4;
  localparam logic [OPW-1:0] OP_IN    = 4'd5;
  localparam logic [OPW-1:0] OP_OUT   = 4'd6;
  localparam logic [OPW-1:0] OP_JC    = 4'd7;
  localparam logic [OPW-1:0] OP_JZ    = 4'd8;
  localparam logic [OPW-1:0] OP_JNC   = 4'd9;
  localparam logic [OPW-1:0] OP_JNZ   = 4'd10;
  localparam logic [OPW-1:0] OP_ADC   = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_EXEC2 = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_sequencer.sv
// Execute-stage controller for the Nibbler datapath. Accepts one decoded
// instruction per valid/ready handshake, drives the external ALU and writes
// back accumulator, C/Z flags and the output port.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   instr_valid/ready/op/imm   instruction handshake (ready only in IDLE)
//   in_port                    external input nibble (sampled in EXEC of IN)
//   alu_a/b/s                  ALU operand and select drive
//   alu_y/zero/cout            ALU result
//   acc, flag_c, flag_z        architectural state
//   out_port                   output register
//   done, branch_taken, illegal  one-cycle registered pulses
//
// state    | meaning
// ST_IDLE  | ready; ALU passes acc; retire pulses visible here
// ST_EXEC  | ALU runs the latched op; writeback at the end (except ADC)
// ST_EXEC2 | ADC only: add the pre-instruction carry to the partial sum
module alu_sequencer
  import nibbler_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [OPW-1:0]   instr_op,
  input  logic [WIDTH-1:0] instr_imm,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_s,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero,
  input  logic             alu_cout,
  output logic [WIDTH-1:0] acc,
  output logic             flag_c,
  output logic             flag_z,
  output logic [WIDTH-1:0] out_port,
  output logic             done,
  output logic             branch_taken,
  output logic             illegal
);

  seq_state_e       state_q, state_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic             c1_q, c1_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             done_q, done_d;
  logic             br_q, br_d;
  logic             ill_q, ill_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      imm_q   <= '0;
      t_q     <= '0;
      c1_q    <= 1'b0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
      br_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      t_q     <= t_d;
      c1_q    <= c1_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      z_q     <= z_d;
      out_q   <= out_d;
      done_q  <= done_d;
      br_q    <= br_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    imm_d       = imm_q;
    t_d         = t_q;
    c1_d        = c1_q;
    acc_d       = acc_q;
    c_d         = c_q;
    z_d         = z_q;
    out_d       = out_q;
    done_d      = 1'b0;
    br_d        = 1'b0;
    ill_d       = 1'b0;
    instr_ready = 1'b0;
    alu_a       = acc_q;
    alu_b       = '0;
    alu_s       = ALU_PASS_A;

    unique case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          op_d    = instr_op;
          imm_d   = instr_imm;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        alu_b   = imm_q;
        state_d = ST_IDLE;
        done_d  = 1'b1;
        case (op_q)
          OP_NOP: ;
          OP_LIT: begin
            alu_s = ALU_PASS_B;
            acc_d = alu_y;
            z_d   = alu_zero;
          end
          OP_ADDI: begin
            alu_s = ALU_ADD;
            acc_d = alu_y;
            c_d   = alu_cout;
            z_d   = alu_zero;
          end
          OP_CMPI: begin
            alu_s = ALU_SUB;
            c_d   = alu_cout;
            z_d   = alu_zero;
          end
          OP_NANDI: begin
            alu_s = ALU_NAND;
            acc_d = alu_y;
            z_d   = alu_zero;
          end
          OP_IN: begin
            alu_s = ALU_PASS_B;
            alu_b = in_port;
            acc_d = alu_y;
            z_d   = alu_zero;
          end
          OP_OUT: begin
            alu_s = ALU_PASS_A;
            out_d = alu_y;
          end
          OP_JC:  br_d = c_q;
          OP_JZ:  br_d = z_q;
          OP_JNC: br_d = ~c_q;
          OP_JNZ: br_d = ~z_q;
          OP_ADC: begin
            alu_s   = ALU_ADD;
            t_d     = alu_y;
            c1_d    = alu_cout;
            state_d = ST_EXEC2;
            done_d  = 1'b0;
          end
          default: ill_d = 1'b1;
        endcase
      end

      ST_EXEC2: begin
        // c_q still holds the carry from before ADC: nothing writes it in EXEC.
        alu_s   = ALU_ADD;
        alu_a   = t_q;
        alu_b   = {{(WIDTH-1){1'b0}}, c_q};
        acc_d   = alu_y;
        c_d     = c1_q | alu_cout;
        z_d     = alu_zero;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign acc          = acc_q;
  assign flag_c       = c_q;
  assign flag_z       = z_q;
  assign out_port     = out_q;
  assign done         = done_q;
  assign branch_taken = br_q;
  assign illegal      = ill_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
  import nibbler_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             instr_valid;
  logic             instr_ready;
  logic [OPW-1:0]   instr_op;
  logic [WIDTH-1:0] instr_imm;
  logic [WIDTH-1:0] in_port;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic [2:0]       alu_s;
  logic             alu_zero, alu_cout;
  logic [WIDTH-1:0] acc, out_port;
  logic             flag_c, flag_z, done, branch_taken, illegal;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_imm(instr_imm), .in_port(in_port),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_y(alu_y), .alu_zero(alu_zero), .alu_cout(alu_cout),
    .acc(acc), .flag_c(flag_c), .flag_z(flag_z), .out_port(out_port),
    .done(done), .branch_taken(branch_taken), .illegal(illegal)
  );

  // Reference ALU sitting beside the sequencer.
  logic [WIDTH:0] alu_wide;
  always_comb begin
    alu_wide = '0;
    case (alu_s)
      ALU_PASS_A: alu_wide = {1'b0, alu_a};
      ALU_SUB:    alu_wide = {(alu_a < alu_b), alu_a - alu_b};
      ALU_PASS_B: alu_wide = {1'b0, alu_b};
      ALU_ADD:    alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_NAND:   alu_wide = {1'b0, ~(alu_a & alu_b)};
      default:    alu_wide = '0;
    endcase
  end
  assign alu_y    = alu_wide[WIDTH-1:0];
  assign alu_cout = alu_wide[WIDTH];
  assign alu_zero = (alu_y == '0);

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one handshake; returns in the EXEC cycle.
  task automatic issue(input logic [3:0] op, input logic [3:0] imm);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_imm   = imm;
    step();
    instr_valid = 1'b0;
  endtask

  // Issue and run through writeback; returns in the retire (IDLE) cycle.
  task automatic run(input logic [3:0] op, input logic [3:0] imm);
    issue(op, imm);
    step();
    if (op == OP_ADC) step();
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_imm = '0; in_port = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_acc", acc, 8'h0);
    chk("rst_c", flag_c, 8'h0);
    chk("rst_z", flag_z, 8'h0);
    chk("rst_out", out_port, 8'h0);
    chk("rst_done", done, 8'h0);
    chk("rst_ready", instr_ready, 8'h1);
    chk("rst_idle_s", alu_s, 8'h0);

    issue(OP_LIT, 4'h9);
    chk("lit_exec_s", alu_s, 8'h2);
    chk("lit_exec_b", alu_b, 8'h9);
    chk("lit_exec_ready", instr_ready, 8'h0);
    step();
    chk("lit_acc", acc, 8'h9);
    chk("lit_z", flag_z, 8'h0);
    chk("lit_c", flag_c, 8'h0);
    chk("lit_done", done, 8'h1);
    chk("lit_ready", instr_ready, 8'h1);
    step();
    chk("lit_done_pulse", done, 8'h0);

    run(OP_LIT, 4'hF);
    run(OP_ADDI, 4'h3);
    chk("addi_acc", acc, 8'h2);
    chk("addi_c", flag_c, 8'h1);
    chk("addi_z", flag_z, 8'h0);
    run(OP_NANDI, 4'hF);
    chk("nandi_acc", acc, 8'hD);
    chk("nandi_c", flag_c, 8'h1);
    chk("nandi_z", flag_z, 8'h0);

    run(OP_LIT, 4'h5);
    run(OP_CMPI, 4'h5);
    chk("cmpeq_acc", acc, 8'h5);
    chk("cmpeq_z", flag_z, 8'h1);
    chk("cmpeq_c", flag_c, 8'h0);
    run(OP_CMPI, 4'h7);
    chk("cmplt_acc", acc, 8'h5);
    chk("cmplt_c", flag_c, 8'h1);
    chk("cmplt_z", flag_z, 8'h0);

    run(OP_LIT, 4'hF);
    run(OP_ADDI, 4'h1);
    chk("wrap_acc", acc, 8'h0);
    chk("wrap_c", flag_c, 8'h1);
    chk("wrap_z", flag_z, 8'h1);

    issue(OP_ADC, 4'hF);
    chk("adc_e1_s", alu_s, 8'h3);
    chk("adc_e1_y", alu_y, 8'hF);
    chk("adc_e1_cout", alu_cout, 8'h0);
    step();
    chk("adc_e2_a", alu_a, 8'hF);
    chk("adc_e2_b", alu_b, 8'h1);
    chk("adc_e2_y", alu_y, 8'h0);
    chk("adc_e2_done", done, 8'h0);
    chk("adc_e2_ready", instr_ready, 8'h0);
    step();
    chk("adc_acc", acc, 8'h0);
    chk("adc_c", flag_c, 8'h1);
    chk("adc_z", flag_z, 8'h1);
    chk("adc_done", done, 8'h1);

    run(OP_JZ, 4'h0);
    chk("jz_br", branch_taken, 8'h1);
    chk("jz_done", done, 8'h1);
    run(OP_JNZ, 4'h0);
    chk("jnz_br", branch_taken, 8'h0);
    run(OP_JC, 4'h0);
    chk("jc_br", branch_taken, 8'h1);
    run(OP_JNC, 4'h0);
    chk("jnc_br", branch_taken, 8'h0);
    run(4'hC, 4'h3);
    chk("ill_pulse", illegal, 8'h1);
    chk("ill_done", done, 8'h1);
    chk("ill_acc", acc, 8'h0);
    chk("ill_c", flag_c, 8'h1);
    chk("ill_z", flag_z, 8'h1);
    step();
    chk("ill_pulse_end", illegal, 8'h0);

    run(OP_OUT, 4'h0);
    chk("out_zero", out_port, 8'h0);
    run(OP_LIT, 4'hA);
    run(OP_OUT, 4'h0);
    chk("out_a", out_port, 8'hA);
    chk("out_z_kept", flag_z, 8'h0);

    in_port = 4'h6;
    issue(OP_IN, 4'h0);
    chk("in_exec_b", alu_b, 8'h6);
    step();
    chk("in_acc", acc, 8'h6);
    chk("in_z", flag_z, 8'h0);

    run(OP_LIT, 4'h7);
    issue(OP_ADC, 4'h1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_acc", acc, 8'h0);
    chk("abort_c", flag_c, 8'h0);
    chk("abort_z", flag_z, 8'h0);
    chk("abort_done", done, 8'h0);
    chk("abort_ready", instr_ready, 8'h1);

    instr_valid = 1'b1; instr_op = OP_LIT; instr_imm = 4'h3;
    step();
    chk("hold_exec_ready", instr_ready, 8'h0);
    instr_op = OP_ADDI; instr_imm = 4'h1;
    step();
    chk("hold_wb_acc", acc, 8'h3);
    chk("hold_wb_ready", instr_ready, 8'h1);
    step();
    instr_valid = 1'b0;
    chk("hold_exec2_s", alu_s, 8'h3);
    chk("hold_exec2_a", alu_a, 8'h3);
    step();
    chk("hold_acc", acc, 8'h4);
    chk("hold_done", done, 8'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
